// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences the PC, strobes the combinational
// instruction memory, captures the word into IR and offers it to decode
// over a valid/ready handshake. Runs PROG_LEN words once, or loops forever.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PROG_LEN = 4,
    parameter bit          LOOP     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_cs,
    input  logic [DATA_W-1:0] im_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [1:0]        r1,
    output logic [1:0]        r2,
    output logic [1:0]        wr,
    output logic              rfe,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       CNT_W    = $clog2(PROG_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(PROG_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic               valid_d;
    logic               fetch_c;
    logic               clear_c;
    logic               count_inc_c;
    logic               last_c;

    // The transfer in flight is the final one of a non-looping run
    assign last_c = !LOOP && (count_q == LAST_CNT);

    // Next-state and fetch control; halt overrides everything else
    always_comb begin
        state_d     = state_q;
        valid_d     = inst_valid;
        fetch_c     = 1'b0;
        clear_c     = 1'b0;
        count_inc_c = 1'b0;
        if (halt) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        clear_c = 1'b1;
                    end
                end
                S_FETCH: begin
                    fetch_c = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        count_inc_c = 1'b1;
                        if (last_c) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                        end else begin
                            // back-to-back fetch in the same cycle as the transfer
                            fetch_c = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        clear_c = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    clear_c = 1'b1;
                end
            endcase
        end
    end

    // State, valid flag, PC and issue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            inst_valid <= 1'b0;
            pc         <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inst_valid <= valid_d;
            if (clear_c) begin
                pc      <= '0;
                count_q <= '0;
            end else begin
                if (fetch_c) begin
                    pc <= pc + ADDR_W'(1);
                end
                // saturates at PROG_LEN; only meaningful when not looping
                if (count_inc_c && (count_q != MAX_CNT)) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    // Instruction register: captures memory data only on a strobed fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= '0;
        end else if (fetch_c) begin
            inst <= im_data;
        end
    end

    // Memory strobe and address; strobe is never raised without a capture
    assign im_cs   = fetch_c;
    assign im_addr = pc;

    // Field decode straight off the IR
    assign r1  = inst[7:6];
    assign r2  = inst[5:4];
    assign wr  = inst[3:2];
    assign rfe = inst[1];

    // Status decode
    assign busy = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: three instances (single run of 4,
// looping, single-word program) fed from one behavioural memory.
module tb_fetch_unit;

    typedef struct packed {
        logic [7:0] w;
        logic [1:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] mem [4];

    // instance 0: PROG_LEN=4, LOOP=0
    logic       start0, halt0, ready0, cs0, v0, rfe0, busy0, done0;
    logic [1:0] addr0, pc0, r1_0, r2_0, wr_0;
    logic [7:0] data0, inst0;
    // instance 1: PROG_LEN=4, LOOP=1
    logic       start1, halt1, ready1, cs1, v1, rfe1, busy1, done1;
    logic [1:0] addr1, pc1, r1_1, r2_1, wr_1;
    logic [7:0] data1, inst1;
    // instance 2: PROG_LEN=1, LOOP=0
    logic       start2, halt2, ready2, cs2, v2, rfe2, busy2, done2;
    logic [1:0] addr2, pc2, r1_2, r2_2, wr_2;
    logic [7:0] data2, inst2;

    assign data0 = cs0 ? mem[addr0] : 8'h00;
    assign data1 = cs1 ? mem[addr1] : 8'h00;
    assign data2 = cs2 ? mem[addr2] : 8'h00;

    fetch_unit #(.ADDR_W(2), .DATA_W(8), .PROG_LEN(4), .LOOP(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .halt(halt0),
        .im_addr(addr0), .im_cs(cs0), .im_data(data0),
        .inst_valid(v0), .inst_ready(ready0), .inst(inst0),
        .r1(r1_0), .r2(r2_0), .wr(wr_0), .rfe(rfe0),
        .pc(pc0), .busy(busy0), .done(done0));

    fetch_unit #(.ADDR_W(2), .DATA_W(8), .PROG_LEN(4), .LOOP(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .halt(halt1),
        .im_addr(addr1), .im_cs(cs1), .im_data(data1),
        .inst_valid(v1), .inst_ready(ready1), .inst(inst1),
        .r1(r1_1), .r2(r2_1), .wr(wr_1), .rfe(rfe1),
        .pc(pc1), .busy(busy1), .done(done1));

    fetch_unit #(.ADDR_W(2), .DATA_W(8), .PROG_LEN(1), .LOOP(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .halt(halt2),
        .im_addr(addr2), .im_cs(cs2), .im_data(data2),
        .inst_valid(v2), .inst_ready(ready2), .inst(inst2),
        .r1(r1_2), .r2(r2_2), .wr(wr_2), .rfe(rfe2),
        .pc(pc2), .busy(busy2), .done(done2));

    int   tests = 0;
    int   fails = 0;
    int   n1    = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected words of a run: k-th issue is mem[k mod 4], pc already points past it
    task automatic push(input int which, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.w  = mem[k % 4];
            e.pc = 2'((k + 1) % 4);
            case (which)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic mon_check(input string tag, input exp_t e, input logic [7:0] i,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                             input logic f, input logic [1:0] p);
        chk({tag, "_inst"}, 32'(i), 32'(e.w));
        chk({tag, "_r1"},   32'(a), 32'(e.w) >> 6);
        chk({tag, "_r2"},   32'(b), (32'(e.w) >> 4) % 4);
        chk({tag, "_wr"},   32'(c), (32'(e.w) >> 2) % 4);
        chk({tag, "_rfe"},  32'(f), (32'(e.w) >> 1) % 2);
        chk({tag, "_pc"},   32'(p), 32'(e.pc));
    endtask

    // Monitor u0: pop on every transfer; strobe must be low while stalled
    always @(negedge clk) begin
        if (!rst && v0) begin
            if (ready0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL u0_unexpected: got inst %0h, required no transfer", inst0);
                end else begin
                    e0 = q0.pop_front();
                    mon_check("u0", e0, inst0, r1_0, r2_0, wr_0, rfe0, pc0);
                end
            end else begin
                chk("u0_stall_cs", 32'(cs0), 32'd0);
            end
        end
    end

    // Monitor u1: looping instance must never report done
    always @(negedge clk) begin
        if (!rst && v1 && ready1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL u1_unexpected: got inst %0h, required no transfer", inst1);
            end else begin
                e1 = q1.pop_front();
                mon_check("u1", e1, inst1, r1_1, r2_1, wr_1, rfe1, pc1);
                chk("u1_done", 32'(done1), 32'd0);
                n1++;
            end
        end
    end

    // Monitor u2
    always @(negedge clk) begin
        if (!rst && v2 && ready2) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL u2_unexpected: got inst %0h, required no transfer", inst2);
            end else begin
                e2 = q2.pop_front();
                mon_check("u2", e2, inst2, r1_2, r2_2, wr_2, rfe2, pc2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input int bound, input bit rnd);
        for (int i = 0; i < bound; i++) begin
            if (done0) break;
            step();
            if (rnd) ready0 = ($urandom_range(0, 3) != 0);
        end
        ready0 = 1'b1;
        chk("u0_done_reached", 32'(done0), 32'd1);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_valid"}, 32'(v0),    32'd0);
        chk({tag, "_pc"},    32'(pc0),   32'd0);
        chk({tag, "_inst"},  32'(inst0), 32'd0);
        chk({tag, "_done"},  32'(done0), 32'd0);
        chk({tag, "_busy"},  32'(busy0), 32'd0);
        chk({tag, "_cs"},    32'(cs0),   32'd0);
        chk({tag, "_addr"},  32'(addr0), 32'd0);
    endtask

    task automatic set_directed();
        mem[0] = 8'h24; mem[1] = 8'h84; mem[2] = 8'h60; mem[3] = 8'hB0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start0 = 0; halt0 = 0; ready0 = 0;
        start1 = 0; halt1 = 0; ready1 = 0;
        start2 = 0; halt2 = 0; ready2 = 0;
        set_directed();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset0("reset");
        step();
        rst = 1'b0;
        step();

        // directed single run, ready held high
        push(0, 4);
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        @(negedge clk);
        chk("c1_cs",    32'(cs0),   32'd1);
        chk("c1_addr",  32'(addr0), 32'd0);
        chk("c1_busy",  32'(busy0), 32'd1);
        chk("c1_valid", 32'(v0),    32'd0);
        step();
        @(negedge clk);
        chk("c2_valid", 32'(v0),    32'd1);
        chk("c2_inst",  32'(inst0), 32'h24);
        repeat (4) step();
        @(negedge clk);
        chk("c6_done",  32'(done0), 32'd1);
        chk("c6_valid", 32'(v0),    32'd0);
        chk("c6_cs",    32'(cs0),   32'd0);
        chk("c6_busy",  32'(busy0), 32'd0);
        chk("run1_q_empty", 32'(q0.size()), 32'd0);

        // restart from DONE, backpressure on 0x84, start ignored in ISSUE
        push(0, 4);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        @(negedge clk);
        chk("restart_done_drop", 32'(done0), 32'd0);
        chk("restart_cs",        32'(cs0),   32'd1);
        step();
        @(negedge clk);
        chk("restart_inst", 32'(inst0), 32'h24);
        chk("restart_valid", 32'(v0),   32'd1);
        step();
        ready0 = 1'b0;
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inst",  32'(inst0), 32'h84);
            chk("bp_pc",    32'(pc0),   32'd2);
            chk("bp_valid", 32'(v0),    32'd1);
            chk("bp_busy",  32'(busy0), 32'd1);
            step();
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        wait_done0(20, 1'b0);
        chk("bp_q_empty", 32'(q0.size()), 32'd0);

        // halt coinciding with the transfer of 0x60
        push(0, 3);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        step();
        step();
        halt0 = 1'b1;
        step();
        halt0 = 1'b0;
        @(negedge clk);
        chk("halt_valid", 32'(v0),    32'd0);
        chk("halt_pc",    32'(pc0),   32'd0);
        chk("halt_busy",  32'(busy0), 32'd0);
        chk("halt_done",  32'(done0), 32'd0);
        chk("halt_cs",    32'(cs0),   32'd0);
        chk("halt_ir",    32'(inst0), 32'h60);
        chk("halt_q_empty", 32'(q0.size()), 32'd0);
        step();

        // replay after halt with random backpressure
        push(0, 4);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_done0(100, 1'b1);
        chk("replay_q_empty", 32'(q0.size()), 32'd0);

        // randomized programs and backpressure
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
            push(0, 4);
            start0 = 1'b1;
            step();
            start0 = 1'b0;
            wait_done0(100, 1'b1);
            chk("rand_q_empty", 32'(q0.size()), 32'd0);
        end

        // asynchronous reset between edges while in ISSUE
        set_directed();
        push(0, 4);
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset0("async_rst");
        q0.delete();
        step();
        rst = 1'b0;
        step();

        // looping instance: 10 transfers, wrap, never done
        push(1, 10);
        ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (n1 >= 10) break;
        end
        ready1 = 1'b0;
        halt1  = 1'b1;
        chk("loop_count", 32'(n1), 32'd10);
        chk("loop_done",  32'(done1), 32'd0);
        step();
        halt1 = 1'b0;
        @(negedge clk);
        chk("loop_halt_valid", 32'(v1),    32'd0);
        chk("loop_halt_busy",  32'(busy1), 32'd0);
        chk("loop_q_empty", 32'(q1.size()), 32'd0);

        // single-word program
        push(2, 1);
        ready2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        @(negedge clk);
        chk("one_valid", 32'(v2),    32'd1);
        chk("one_inst",  32'(inst2), 32'h24);
        step();
        @(negedge clk);
        chk("one_done",  32'(done2), 32'd1);
        chk("one_valid_low", 32'(v2), 32'd0);
        chk("one_cs",    32'(cs2),   32'd0);
        chk("one_q_empty", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
